uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the SOC's single TXD serial line between two byte requesters (req0: CPU MMIO UART
//   register, req1: LED-change/debug logger). Round-robin arbitration per byte, then
//   serialises 8N1 onto TXD with an internal baud counter. Sits between the SOC bus
//   decoder and the TXD top-level pin.
// PARAMETERS
//   CLK_FREQ_HZ  25_000_000  system clock frequency (40 ns period)
//   BAUD         115200      line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide, >=2)
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   reset        in   1  synchronous, active-high reset
//   req0_valid   in   1  requester 0 has a byte; must hold with stable data until accepted
//   req0_data    in   8  requester 0 byte
//   req0_ready   out  1  requester 0 byte accepted this cycle (valid&&ready = transfer)
//   req1_valid   in   1  requester 1 has a byte
//   req1_data    in   8  requester 1 byte
//   req1_ready   out  1  requester 1 byte accepted this cycle
//   TXD          out  1  serial output, registered, idle high
//   busy         out  1  high from accept edge until frame end (registered)
//   grant_id     out  1  id of requester owning current/last frame (registered)
// BEHAVIOUR
//   - Reset: TXD=1, busy=0, grant_id=0, state=IDLE, bit/baud counters=0, last_grant=1
//     (req0 wins first tie). Reset mid-frame aborts: TXD=1 on next edge, byte dropped.
//   - States: IDLE -> START -> DATA(8 bits, LSB first) -> [PARITY] -> STOP -> IDLE.
//   - IDLE: readyK combinational, high only in IDLE for the selected requester; others 0.
//     Selection: only one valid -> that one; both valid -> the one != last_grant.
//   - Accept edge: latch data into shift reg, last_grant/grant_id<=id, busy<=1, state<=START;
//     TXD=0 from that edge.
//   - Each bit held exactly CLKS_PER_BIT cycles (baud counter 0..CLKS_PER_BIT-1, restarts per bit).
//   - STOP: TXD=1 for CLKS_PER_BIT cycles, then IDLE with busy<=0; >=1 IDLE cycle between
//     frames -> back-to-back period = 10*CLKS_PER_BIT+1 cycles (11*... with parity).
//   - readyK never high outside IDLE; valid deasserting before accept is legal (no transfer).
//   - Counters never wrap: bit counter 0..7, baud counter bounded by CLKS_PER_BIT-1.
// CONFIGURATION
//   - UART_TX_PARITY_EN defined: PARITY state after DATA sends even parity (XOR of 8 bits)
//     for CLKS_PER_BIT cycles; frame is 8E1, 11 bit times.
//   - Not defined: no PARITY state, 8N1, 10 bit times; state encoding unchanged otherwise.
// STRUCTURE
//   - Shared include soc_uart_defs.vh: state localparams (IDLE/START/DATA/PARITY/STOP),
//     CLKS_PER_BIT computation macro, reused by future uart_rx.
//   - One sub-module: uart_baud_tick (counter, restart input, tick output at CLKS_PER_BIT-1).
//   - Arbiter + FSM + shift reg in this module.
// TESTING  (bench: CLK_FREQ_HZ=1000, BAUD=250 -> CLKS_PER_BIT=4)
//   - Reset held 3 cycles -> TXD=1, busy=0, req0_ready=req1_ready=0 while reset high.
//   - req0 sends 8'hA5 -> TXD: 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles; grant_id=0.
//   - req0 and req1 valid same cycle (8'h11, 8'h22) -> 8'h11 first, 8'h22 next; 2nd start bit
//     41 cycles after 1st; grant_id 0 then 1.
//   - Both held valid for 4 frames -> grants alternate 0,1,0,1; no requester starves.
//   - reset pulsed at cycle 15 of a frame -> TXD=1 next edge, busy=0, new byte restarts cleanly.
//   - UART_TX_PARITY_EN, send 8'h07 -> parity bit 1, frame 44 cycles; 8'h03 -> parity 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the bit-period helper. The PARITY state keeps its encoding in every build
// so that state values seen on the debug port never shift between builds.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Number of system clocks per serial bit (integer divide).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_baud_tick.sv
// Bit-period counter. It counts 0..CLKS_PER_BIT-1 and raises tick during the
// last cycle of each bit. restart holds it at 0, so the first bit period
// after a restart has the full length.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-running bit-period counter that wraps at the last cycle of a bit.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one 8N1 UART transmitter.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data (8E1).
//
// Handshake: reqK_ready is combinational and is high only in IDLE, only for
// the requester selected this cycle and only while its valid is high. A byte
// moves on any rising edge where valid && ready. The requester must hold
// data stable while valid is high and not yet accepted; dropping valid
// before acceptance is allowed and transfers nothing.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       TXD,
  output logic       busy,
  output logic       grant_id,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

  state_t     state_q, state_n;
  logic       txd_q, txd_n;
  logic       busy_q, busy_n;
  logic       grant_q, grant_n;
  logic       last_q, last_n;
  logic [7:0] shift_q, shift_n;
  logic [2:0] bit_q, bit_n;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_n;
`endif

  logic sel;
  logic idle;
  logic accept;
  logic tick;

  // On a tie the requester that did not own the previous frame wins.
  assign sel        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign idle       = (state_q == ST_IDLE);
  assign req0_ready = idle && !reset && req0_valid && !sel;
  assign req1_ready = idle && !reset && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(idle),
    .tick   (tick)
  );

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_n = state_q;
    txd_n   = txd_q;
    busy_n  = busy_q;
    grant_n = grant_q;
    last_n  = last_q;
    shift_n = shift_q;
    bit_n   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_START;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
          grant_n = sel;
          last_n  = sel;
          shift_n = sel ? req1_data : req0_data;
          bit_n   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_n   = sel ? ^req1_data : ^req0_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_n = ST_DATA;
          txd_n   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
            txd_n   = par_q;
`else
            state_n = ST_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            bit_n   = bit_q + 3'd1;
            shift_n = shift_q >> 1;
            txd_n   = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (tick) begin
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end
`else
        state_n = ST_IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
`endif
      end
      ST_STOP: begin
        if (tick) begin
          state_n = ST_IDLE;
          txd_n   = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      txd_q   <= txd_n;
      busy_q  <= busy_n;
      grant_q <= grant_n;
      last_q  <= last_n;
      shift_q <= shift_n;
      bit_q   <= bit_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign TXD       = txd_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLK_FREQ_HZ=1000, BAUD=250 (4 clocks
// per bit). Honours UART_TX_PARITY_EN to expect 8E1 frames.
module tb_uart_tx_arbiter;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int BAUD        = 250;
  localparam int CPB         = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       reset;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       TXD;
  logic       busy;
  logic       grant_id;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [0:0] exp_q[$];

  uart_tx_arbiter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .TXD       (TXD),
    .busy      (busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) until some ready is high; the next rising edge accepts.
  task automatic wait_accept(output logic id, output int acc_cyc);
    logic seen;
    id = 1'b0;
    acc_cyc = 0;
    seen = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (req0_ready || req1_ready) begin
        seen = 1'b1;
        break;
      end
      step();
      #1;
    end
    if (!seen) begin
      chk1("accept_timeout", 1'b0, 1'b1);
    end else begin
      chk1("single_ready", req0_ready && req1_ready, 1'b0);
      id = req1_ready;
      acc_cyc = cyc + 1;
    end
  endtask

  // Check a whole frame bit by bit, then the idle cycle that follows it.
  // On the first frame cycle the granted requester gets new data and may drop valid.
  task automatic check_frame(input logic [7:0] d, input logic id,
                             input logic drop, input logic [7:0] nd);
    logic [0:0] b_exp;
    exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
    for (int b = 0; b < FB; b++) begin
      b_exp = exp_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        step();
        if (b == 0 && c == 0) begin
          chk1("grant_id", grant_id, id);
          if (!id) begin
            req0_data = nd;
            if (drop) req0_valid = 1'b0;
          end else begin
            req1_data = nd;
            if (drop) req1_valid = 1'b0;
          end
        end
        chk1($sformatf("txd_bit%0d_c%0d", b, c), TXD, b_exp);
        chk1("busy_in_frame", busy, 1'b1);
        chk1("ready_outside_idle", req0_ready || req1_ready, 1'b0);
      end
    end
    step();
    chk1("busy_after_frame", busy, 1'b0);
    chk1("txd_idle_after_frame", TXD, 1'b1);
  endtask

  // Directed stimulus.
  initial begin
    logic id;
    logic exp_id;
    int a1, a2;
    logic [7:0] cur0, cur1;

    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 8'h00;
    req1_data = 8'h00;

    // Reset held for 3 cycles with both requesters asserting valid.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rst_txd", TXD, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_ready0", req0_ready, 1'b0);
      chk1("rst_ready1", req1_ready, 1'b0);
      chk1("rst_grant", grant_id, 1'b0);
      chk_int("rst_state", int'(dbg_state), 0);
      if (i < 2) @(posedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    step();
    chk1("idle_txd", TXD, 1'b1);
    chk1("idle_busy", busy, 1'b0);

    // Single byte 8'hA5 from requester 0.
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    wait_accept(id, a1);
    chk1("a5_id", id, 1'b0);
    check_frame(8'hA5, 1'b0, 1'b1, 8'h00);

    // Reset pulse at cycle 15 of a frame from requester 1.
    req1_data = 8'h3C;
    req1_valid = 1'b1;
    wait_accept(id, a1);
    chk1("3c_id", id, 1'b1);
    step();
    req1_valid = 1'b0;
    for (int i = 2; i <= 15; i++) step();
    chk1("mid_txd_bit2", TXD, 1'b1);
    chk1("mid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    chk1("abort_txd", TXD, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk_int("abort_state", int'(dbg_state), 0);
    reset = 1'b0;
    step();
    chk1("post_abort_busy", busy, 1'b0);
    chk1("post_abort_grant", grant_id, 1'b0);
    req1_data = 8'h5A;
    req1_valid = 1'b1;
    wait_accept(id, a1);
    chk1("5a_id", id, 1'b1);
    check_frame(8'h5A, 1'b1, 1'b1, 8'h00);

    // Simultaneous requests: req0 (last owner was req1) goes first.
    req0_data = 8'h11;
    req1_data = 8'h22;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accept(id, a1);
    chk1("tie_first_id", id, 1'b0);
    check_frame(8'h11, 1'b0, 1'b1, 8'h00);
    wait_accept(id, a2);
    chk1("tie_second_id", id, 1'b1);
    chk_int("tie_start_spacing", a2 - a1, FB * CPB + 1);
    check_frame(8'h22, 1'b1, 1'b1, 8'h00);

    // Both held valid for four frames: grants alternate 0,1,0,1.
    cur0 = 8'h40;
    cur1 = 8'h80;
    req0_data = cur0;
    req1_data = cur1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    a1 = 0;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2) == 1;
      wait_accept(id, a2);
      chk1($sformatf("alt_id_%0d", k), id, exp_id);
      if (k > 0) chk_int($sformatf("alt_spacing_%0d", k), a2 - a1, FB * CPB + 1);
      a1 = a2;
      if (!exp_id) begin
        check_frame(cur0, 1'b0, 1'b0, cur0 + 8'd1);
        cur0 = cur0 + 8'd1;
      end else begin
        check_frame(cur1, 1'b1, k == 3, cur1 + 8'd1);
        cur1 = cur1 + 8'd1;
      end
    end
    // req0 is selected now; withdrawing valid before the edge transfers nothing.
    req0_valid = 1'b0;
    #1;
    chk1("withdraw_ready0", req0_ready, 1'b0);
    step();
    chk1("withdraw_busy", busy, 1'b0);
    chk_int("withdraw_state", int'(dbg_state), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 8'h07 -> 1, 8'h03 -> 0.
    req0_data = 8'h07;
    req0_valid = 1'b1;
    wait_accept(id, a1);
    chk1("par07_id", id, 1'b0);
    check_frame(8'h07, 1'b0, 1'b1, 8'h00);
    req0_data = 8'h03;
    req0_valid = 1'b1;
    wait_accept(id, a1);
    chk1("par03_id", id, 1'b0);
    check_frame(8'h03, 1'b0, 1'b1, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
